// File: rtl/pc_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : pc_fetch_ctrl
// Function : Fetch-stage PC owner; sequences req/ack fetches, arbitrates
//            trap/branch/jump redirects and holds the fetched word for decode.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trap_valid,
   input  logic [31:0] trap_target,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        jmp_valid,
   input  logic [31:0] jmp_target,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic [31:0] pc
);

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] c_PC_STEP    = 32'd4;

   state_t      r_state,       w_state_nxt;
   logic [31:0] r_pc,          w_pc_nxt;
   logic        r_kill_pend,   w_kill_pend_nxt;
   logic [31:0] r_pend_target, w_pend_target_nxt;
   logic        r_if_valid,    w_if_valid_nxt;
   logic [31:0] r_if_pc,       w_if_pc_nxt;
   logic [31:0] r_if_instr,    w_if_instr_nxt;

   logic        w_redirect;
   logic [31:0] w_target;

   assign w_redirect = trap_valid | br_valid | jmp_valid;

   always_comb begin
      w_target = jmp_target;
      if (trap_valid)
         w_target = trap_target;
      else if (br_valid)
         w_target = br_target;
      w_target = w_target & c_ALIGN_MASK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_FETCH;
         r_pc          <= RESET_PC;
         r_kill_pend   <= 1'b0;
         r_pend_target <= 32'h0;
         r_if_valid    <= 1'b0;
         r_if_pc       <= 32'h0;
         r_if_instr    <= 32'h0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_kill_pend   <= w_kill_pend_nxt;
         r_pend_target <= w_pend_target_nxt;
         r_if_valid    <= w_if_valid_nxt;
         r_if_pc       <= w_if_pc_nxt;
         r_if_instr    <= w_if_instr_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_kill_pend_nxt   = r_kill_pend;
      w_pend_target_nxt = r_pend_target;
      w_if_valid_nxt    = r_if_valid;
      w_if_pc_nxt       = r_if_pc;
      w_if_instr_nxt    = r_if_instr;

      case (r_state)
         ST_FETCH: begin
            if (imem_ack) begin
               if (w_redirect || r_kill_pend) begin
                  // Response belongs to a path that has since been redirected.
                  w_kill_pend_nxt = 1'b0;
                  w_pc_nxt        = w_redirect ? w_target : r_pend_target;
               end else begin
                  w_if_valid_nxt = 1'b1;
                  w_if_pc_nxt    = r_pc;
                  w_if_instr_nxt = imem_rdata;
                  w_pc_nxt       = r_pc + c_PC_STEP;
                  w_state_nxt    = ST_FULL;
               end
            end else if (w_redirect) begin
               // Address must stay stable until ack, so park the newest target.
               w_kill_pend_nxt   = 1'b1;
               w_pend_target_nxt = w_target;
            end
         end
         ST_FULL: begin
            if (w_redirect) begin
               w_if_valid_nxt = 1'b0;
               w_pc_nxt       = w_target;
               w_state_nxt    = ST_FETCH;
            end else if (!stall) begin
               w_if_valid_nxt = 1'b0;
               w_state_nxt    = ST_FETCH;
            end
         end
         default: begin
            w_state_nxt = ST_FETCH;
         end
      endcase
   end

   assign imem_req  = (r_state == ST_FETCH);
   assign imem_addr = r_pc;
   assign if_valid  = r_if_valid;
   assign if_pc     = r_if_pc;
   assign if_instr  = r_if_instr;
   assign pc        = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_fetch_ctrl
// Function : Directed self-checking bench for pc_fetch_ctrl with a
//            variable-latency instruction memory model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        trap_valid;
   logic [31:0] trap_target;
   logic        br_valid;
   logic [31:0] br_target;
   logic        jmp_valid;
   logic [31:0] jmp_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [31:0] pc;

   logic [31:0] lat;
   logic        force_ack;
   logic [31:0] wait_cnt;
   int          n_pass;
   int          n_total;

   pc_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
      .clk         (clk),
      .rst         (rst),
      .trap_valid  (trap_valid),
      .trap_target (trap_target),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .jmp_valid   (jmp_valid),
      .jmp_target  (jmp_target),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .pc          (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory acks after lat waiting cycles; rdata is the address scrambled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= 32'd0;
      else if (imem_req && !imem_ack)
         wait_cnt <= wait_cnt + 32'd1;
      else
         wait_cnt <= 32'd0;
   end
   assign imem_ack   = (imem_req && (wait_cnt >= lat)) || force_ack;
   assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;

   task automatic test_reset;
      rst = 1'b1; lat = 32'd0;
      @(negedge clk);
      n_total++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid got=%b exp=0", if_valid); else n_pass++;
      n_total++; if (if_pc !== 32'h0) $display("FAIL rst_if_pc got=%h exp=0", if_pc); else n_pass++;
      n_total++; if (if_instr !== 32'h0) $display("FAIL rst_if_instr got=%h exp=0", if_instr); else n_pass++;
      n_total++; if (pc !== 32'h100) $display("FAIL rst_pc got=%h exp=100", pc); else n_pass++;
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL rst_req got=%b/%h exp=1/100", imem_req, imem_addr); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_sequence_and_stall;
      logic [31:0] exp_addr [3];
      logic [31:0] exp_instr [3];
      exp_addr  = '{32'h100, 32'h104, 32'h108};
      exp_instr = '{32'hA5A5_A4A5, 32'hA5A5_A4A1, 32'h0};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_total++; if (if_valid !== 1'b1 || if_pc !== exp_addr[k] || if_instr !== exp_instr[k])
            $display("FAIL seq_full%0d got=%b/%h/%h exp=1/%h/%h", k, if_valid, if_pc, if_instr, exp_addr[k], exp_instr[k]); else n_pass++;
         n_total++; if (imem_req !== 1'b0) $display("FAIL seq_noreq%0d got=%b exp=0", k, imem_req); else n_pass++;
         if (k == 1) break;
         @(negedge clk);
         n_total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_addr[k+1])
            $display("FAIL seq_fetch%0d got=%b/%b/%h exp=0/1/%h", k, if_valid, imem_req, imem_addr, exp_addr[k+1]); else n_pass++;
      end
      stall = 1'b1; force_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_instr !== 32'hA5A5_A4A1 || imem_req !== 1'b0)
            $display("FAIL stall_hold%0d got=%b/%h/%h/%b exp=1/104/a5a5a4a1/0", k, if_valid, if_pc, if_instr, imem_req); else n_pass++;
      end
      stall = 1'b0; force_ack = 1'b0;
      @(negedge clk);
      n_total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_addr[2])
         $display("FAIL stall_release got=%b/%b/%h exp=0/1/108", if_valid, imem_req, imem_addr); else n_pass++;
   endtask

   task automatic test_branch_kill;
      rst = 1'b1; lat = 32'd3;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h100) $display("FAIL lat_first got=%b/%h exp=1/100", if_valid, if_pc); else n_pass++;
      @(negedge clk);
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) $display("FAIL lat_req104 got=%b/%h exp=1/104", imem_req, imem_addr); else n_pass++;
      @(negedge clk);
      br_valid = 1'b1; br_target = 32'h200;
      @(negedge clk);
      br_valid = 1'b0;
      n_total++; if (imem_addr !== 32'h104 || if_valid !== 1'b0) $display("FAIL br_addr_stable got=%h/%b exp=104/0", imem_addr, if_valid); else n_pass++;
      @(negedge clk);
      n_total++; if (imem_ack !== 1'b1 || imem_addr !== 32'h104) $display("FAIL br_ack_cycle got=%b/%h exp=1/104", imem_ack, imem_addr); else n_pass++;
      @(negedge clk);
      n_total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
         $display("FAIL br_killed got=%b/%b/%h exp=0/1/200", if_valid, imem_req, imem_addr); else n_pass++;
   endtask

   task automatic test_priority;
      lat = 32'd0;
      @(negedge clk);
      n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'hA5A5_A7A5)
         $display("FAIL prio_full got=%b/%h/%h exp=1/200/a5a5a7a5", if_valid, if_pc, if_instr); else n_pass++;
      stall = 1'b1;
      trap_valid = 1'b1; trap_target = 32'h80;
      br_valid   = 1'b1; br_target   = 32'h200;
      jmp_valid  = 1'b1; jmp_target  = 32'h300;
      @(negedge clk);
      trap_valid = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0; stall = 1'b0;
      n_total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80)
         $display("FAIL prio_trap got=%b/%b/%h exp=0/1/80", if_valid, imem_req, imem_addr); else n_pass++;
   endtask

   task automatic test_newest_wins;
      lat = 32'd3;
      jmp_valid = 1'b1; jmp_target = 32'h300;
      @(negedge clk);
      jmp_valid = 1'b0;
      n_total++; if (imem_addr !== 32'h80 || if_valid !== 1'b0) $display("FAIL nw_hold1 got=%h/%b exp=80/0", imem_addr, if_valid); else n_pass++;
      @(negedge clk);
      br_valid = 1'b1; br_target = 32'h400;
      @(negedge clk);
      br_valid = 1'b0;
      n_total++; if (imem_addr !== 32'h80 || imem_req !== 1'b1) $display("FAIL nw_hold2 got=%h/%b exp=80/1", imem_addr, imem_req); else n_pass++;
      @(negedge clk);
      n_total++; if (imem_addr !== 32'h400 || if_valid !== 1'b0 || imem_req !== 1'b1)
         $display("FAIL nw_target got=%h/%b/%b exp=400/0/1", imem_addr, if_valid, imem_req); else n_pass++;
      lat = 32'd0;
      @(negedge clk);
      n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h400 || if_instr !== 32'hA5A5_A1A5)
         $display("FAIL nw_fetched got=%b/%h/%h exp=1/400/a5a5a1a5", if_valid, if_pc, if_instr); else n_pass++;
   endtask

   task automatic test_wrap_and_align;
      jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
      @(negedge clk);
      jmp_valid = 1'b0;
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req, imem_addr); else n_pass++;
      @(negedge clk);
      n_total++; if (if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h5A5A_5A59 || pc !== 32'h0)
         $display("FAIL wrap_pc got=%h/%h/%h exp=fffffffc/5a5a5a59/0", if_pc, if_instr, pc); else n_pass++;
      @(negedge clk);
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr); else n_pass++;
      // Redirect coincides with the zero-wait ack of address 0.
      jmp_valid = 1'b1; jmp_target = 32'h0000_0013;
      @(negedge clk);
      jmp_valid = 1'b0;
      n_total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10)
         $display("FAIL align_kill got=%b/%b/%h exp=0/1/10", if_valid, imem_req, imem_addr); else n_pass++;
      @(negedge clk);
      n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'hA5A5_A5B5)
         $display("FAIL align_fetch got=%b/%h/%h exp=1/10/a5a5a5b5", if_valid, if_pc, if_instr); else n_pass++;
   endtask

   task automatic test_async_reset;
      #2;
      rst = 1'b1;
      #1;
      n_total++; if (pc !== 32'h100 || if_valid !== 1'b0 || if_pc !== 32'h0 || imem_addr !== 32'h100)
         $display("FAIL async_rst got=%h/%b/%h/%h exp=100/0/0/100", pc, if_valid, if_pc, imem_addr); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b1; lat = 32'd0; force_ack = 1'b0; stall = 1'b0;
      trap_valid = 1'b0; trap_target = 32'h0;
      br_valid = 1'b0;   br_target = 32'h0;
      jmp_valid = 1'b0;  jmp_target = 32'h0;
      test_reset;
      test_sequence_and_stall;
      test_branch_kill;
      test_priority;
      test_newest_wins;
      test_wrap_and_align;
      test_async_reset;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
